nonblocking_pipeline: RTL and testbench



---
 rtl/nonblocking_pipeline_pkg.sv | 23 ++
 rtl/nonblocking_pipeline_pipe_stage.sv | 38 +++
 rtl/nonblocking_pipeline.sv | 130 +++++++++++++
 tb/tb_nonblocking_pipeline.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonblocking_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nonblocking_pkg
// Brief    : Shared constants and payload type for the a/b/c -> x pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package nonblocking_pkg;

    // Default operand / result width.
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Number of registered stages between operand acceptance and result.
    localparam int unsigned NUM_STAGES = 3;

    // Stage S1 payload at the default width: operand a (data), b and c.
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] data;
        logic [DEFAULT_WIDTH-1:0] b;
        logic [DEFAULT_WIDTH-1:0] c;
    } s1_payload_t;

endpackage : nonblocking_pkg
`default_nettype wire

// File: rtl/nonblocking_pipeline_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage
// Brief    : One elastic pipeline stage: a valid bit plus a payload register.
//            Loads upstream valid/payload when i_adv is high, holds otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_adv,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Load from upstream when the stage may advance; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : pipe_stage
`default_nettype wire

// File: rtl/nonblocking_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : nonblocking_pipeline
// Brief    : Three-stage valid/ready pipeline computing x = (a ^ b) | c.
//            S1 captures operands, S2 forms a ^ b, S3 forms the final OR.
//            Optional macro NONBLOCKING_PIPELINE_ACCUM_EN adds an XOR
//            accumulator (port acc) over every consumed result.
// Revision : 1.0 - initial release
// ============================================================================
module nonblocking_pipeline
    import nonblocking_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
`ifdef NONBLOCKING_PIPELINE_ACCUM_EN
    output logic [WIDTH-1:0] acc,
`endif
    output logic             busy
);

    // S1 payload at the configured width (same layout as s1_payload_t).
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] c;
    } s2_t;

    logic             w_v1;
    logic             w_v2;
    logic             w_v3;
    logic             w_adv1;
    logic             w_adv2;
    logic             w_adv3;
    s1_t              w_s1_in;
    s1_t              w_s1_q;
    s2_t              w_s2_in;
    s2_t              w_s2_q;
    logic [WIDTH-1:0] w_s3_in;
    logic [WIDTH-1:0] w_s3_q;
    logic [NUM_STAGES-1:0] w_valid;

    // Backpressure chain: a stage may advance if it is empty or its
    // downstream neighbour advances too.
    always_comb begin
        w_adv3 = !w_v3 || out_ready;
        w_adv2 = !w_v2 || w_adv3;
        w_adv1 = !w_v1 || w_adv2;
    end

    // Reset empties every stage, so the input side reports ready while rst
    // is asserted; anything presented then is discarded by the stage reset.
    assign in_ready = rst || w_adv1;

    // Per-stage combinational functions feeding each register.
    always_comb begin
        w_s1_in.data = a;
        w_s1_in.b    = b;
        w_s1_in.c    = c;
        w_s2_in.data = w_s1_q.data ^ w_s1_q.b;
        w_s2_in.c    = w_s1_q.c;
        w_s3_in      = w_s2_q.data | w_s2_q.c;
    end

    pipe_stage #(.DATA_W(3 * WIDTH)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (w_adv1),
        .i_valid (in_valid),
        .i_data  (w_s1_in),
        .o_valid (w_v1),
        .o_data  (w_s1_q)
    );

    pipe_stage #(.DATA_W(2 * WIDTH)) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (w_adv2),
        .i_valid (w_v1),
        .i_data  (w_s2_in),
        .o_valid (w_v2),
        .o_data  (w_s2_q)
    );

    pipe_stage #(.DATA_W(WIDTH)) u_s3 (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (w_adv3),
        .i_valid (w_v2),
        .i_data  (w_s3_in),
        .o_valid (w_v3),
        .o_data  (w_s3_q)
    );

    assign w_valid   = {w_v3, w_v2, w_v1};
    assign busy      = |w_valid;
    assign out_valid = w_v3;
    assign x         = w_s3_q;

`ifdef NONBLOCKING_PIPELINE_ACCUM_EN
    logic [WIDTH-1:0] r_acc;

    // Fold every consumed result into the running XOR signature.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_v3 && out_ready) begin
            r_acc <= r_acc ^ w_s3_q;
        end
    end

    assign acc = r_acc;
`endif

endmodule : nonblocking_pipeline
`default_nettype wire

// File: tb/tb_nonblocking_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_nonblocking_pipeline
// Brief    : Self-checking bench for nonblocking_pipeline: queue-based model
//            compared every cycle plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nonblocking_pipeline;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    wire          in_ready;
    wire          out_valid;
    wire          busy;
    wire  [W-1:0] x;
`ifdef NONBLOCKING_PIPELINE_ACCUM_EN
    wire  [W-1:0] acc;
`endif

    always #5 clk = ~clk;

    nonblocking_pipeline #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
`ifdef NONBLOCKING_PIPELINE_ACCUM_EN
        .acc       (acc),
`endif
        .busy      (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Directed operand generator and expected result for item k.
    function automatic logic [W-1:0] op_a(input int k); return W'(k * 37 + 5); endfunction
    function automatic logic [W-1:0] op_b(input int k); return W'((k * 91) ^ 8'h3C); endfunction
    function automatic logic [W-1:0] op_c(input int k); return W'((k * 13) & 8'h11); endfunction
    function automatic logic [W-1:0] x_of(input int k); return (op_a(k) ^ op_b(k)) | op_c(k); endfunction

    task automatic drive(input int k);
        in_valid = 1'b1;
        a = op_a(k);
        b = op_b(k);
        c = op_c(k);
    endtask

    task automatic drive_raw(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic [W-1:0] rc);
        in_valid = 1'b1;
        a = ra;
        b = rb;
        c = rc;
    endtask

    // ---------------- behavioural model ----------------
    // Items in flight, oldest first; pos is the stage (1..3) holding it.
    typedef struct {
        logic [W-1:0] x;
        int           pos;
    } item_t;

    item_t        q[$];
    bit           mv[0:7];
    bit           m_rdy;
    logic [W-1:0] acc_m = '0;
    bit           chk_en = 1'b0;

    // An item moves forward if the slot ahead frees up or is already free;
    // the oldest item at the last slot leaves only when downstream accepts.
    function automatic void calc();
        for (int i = 0; i < q.size(); i++) begin
            if (i == 0) mv[i] = (q[0].pos < 3) || out_ready;
            else        mv[i] = (q[i].pos + 1 < q[i-1].pos) || mv[i-1];
        end
        m_rdy = rst || (q.size() == 0) || (q[q.size()-1].pos > 1) || mv[q.size()-1];
    endfunction

    always @(posedge clk) begin
        bit    take;
        item_t n;
        item_t t;
        calc();
        if (rst) begin
            q.delete();
            acc_m = '0;
        end else begin
            take  = in_valid && m_rdy;
            n.x   = (a ^ b) | c;
            n.pos = 1;
            for (int i = 0; i < q.size(); i++) begin
                if (mv[i]) begin
                    t = q[i];
                    t.pos++;
                    q[i] = t;
                end
            end
            if (q.size() > 0 && q[0].pos == 4) begin
                acc_m = acc_m ^ q[0].x;
                void'(q.pop_front());
            end
            if (take) q.push_back(n);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        bit exp_v;
        #2;
        if (chk_en) begin
            calc();
            exp_v = (q.size() > 0) && (q[0].pos == 3);
            check("model_out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            if (exp_v) check("model_x", {24'd0, x}, {24'd0, q[0].x});
            check("model_busy", {31'd0, busy}, {31'd0, q.size() > 0});
            check("model_in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
`ifdef NONBLOCKING_PIPELINE_ACCUM_EN
            check("model_acc", {24'd0, acc}, {24'd0, acc_m});
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int idx;
        int outn;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        #3;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_x", {24'd0, x}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); rst = 1'b0;

        // Single transfer: 3-cycle latency, x = CD.
        @(negedge clk); drive_raw(8'hF0, 8'h3C, 8'h01);
        #1 check("single_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #3;
        check("single_out_valid", {31'd0, out_valid}, 32'd1);
        check("single_x", {24'd0, x}, 32'hCD);
        @(negedge clk); #3;
        check("single_busy_drop", {31'd0, busy}, 32'd0);

        // Streaming: 16 back-to-back triples, one result per cycle.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); drive(100 + i);
            #1 check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            if (i >= 3) begin
                check("stream_out_valid", {31'd0, out_valid}, 32'd1);
                check("stream_x", {24'd0, x}, {24'd0, x_of(100 + i - 3)});
            end
        end
        @(negedge clk); in_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Backpressure: only 3 of 5 accepted while out_ready is low.
        idx = 0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            @(negedge clk); out_ready = 1'b0; drive(200 + idx);
            #1;
            if (in_ready) idx++;
            if (cyc >= 3) begin
                check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                check("bp_hold_x", {24'd0, x}, {24'd0, x_of(200)});
            end
        end
        check("bp_accepted", idx, 32'd3);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        outn = 0;
        for (int cyc = 0; cyc < 12 && outn < 5; cyc++) begin
            @(negedge clk); out_ready = 1'b1;
            if (idx < 5) drive(200 + idx);
            else in_valid = 1'b0;
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid) begin
                check("bp_drain_x", {24'd0, x}, {24'd0, x_of(200 + outn)});
                outn++;
            end
        end
        @(negedge clk); in_valid = 1'b0;
        check("bp_drained", outn, 32'd5);
        check("bp_all_accepted", idx, 32'd5);
        repeat (4) @(negedge clk);

        // Full pipeline, then simultaneous consume and accept.
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); out_ready = 1'b0; drive(300 + j);
            #1 check("full_fill_ready", {31'd0, in_ready}, 32'd1);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk); out_ready = 1'b1; drive(303 + j);
            #1;
            check("sim_in_ready", {31'd0, in_ready}, 32'd1);
            check("sim_out_valid", {31'd0, out_valid}, 32'd1);
            check("sim_x", {24'd0, x}, {24'd0, x_of(300 + j)});
        end
        @(negedge clk); in_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Mid-operation reset with two items in flight.
        @(negedge clk); out_ready = 1'b1; drive(400);
        @(negedge clk); drive(401);
        @(negedge clk); rst = 1'b1; drive(402);
        #1 check("rst_in_ready_during", {31'd0, in_ready}, 32'd1);
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_x", {24'd0, x}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk); #3;
            check("rst_no_stale", {31'd0, out_valid}, 32'd0);
        end

`ifdef NONBLOCKING_PIPELINE_ACCUM_EN
        // Accumulator: results CD, 0F, FF -> CD, C2, 3D; reset clears it.
        check("acc_reset", {24'd0, acc}, 32'd0);
        @(negedge clk); drive_raw(8'hF0, 8'h3C, 8'h01);
        @(negedge clk); drive_raw(8'h0F, 8'h00, 8'h00);
        @(negedge clk); drive_raw(8'h00, 8'h00, 8'hFF);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); #3 check("acc_1", {24'd0, acc}, 32'hCD);
        @(negedge clk); #3 check("acc_2", {24'd0, acc}, 32'hC2);
        @(negedge clk); #3 check("acc_3", {24'd0, acc}, 32'h3D);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #3 check("acc_cleared", {24'd0, acc}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_nonblocking_pipeline
`default_nettype wire
